// File: rtl/spi_frame_rx.sv
// SPI slave receiver for the 40-bit status link: oversamples sclk/mosi/cs_n on clk,
// captures one MSB-first frame per chip-select window and decodes the status fields.
//
// state | meaning
// IDLE  | chip select released, waiting for s_cs_n low
// ARM   | selected, waiting for the first sclk rising edge
// SHIFT | sampling mosi on each sclk falling edge
// DONE  | one cycle: accept full frame or flag a short one
module spi_frame_rx #(
   parameter int FRAME_BITS  = 40,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  sclk,
   input  logic                  mosi,
   input  logic                  cs_n,
   output logic [FRAME_BITS-1:0] frame_data,
   output logic [7:0]            a_val,
   output logic [7:0]            b_val,
   output logic [7:0]            acc_val,
   output logic [3:0]            pc_val,
   output logic [2:0]            state_val,
   output logic                  frame_valid,
   output logic                  frame_err,
   output logic [7:0]            frame_count,
   output logic                  busy
);

   localparam int CW = $clog2(FRAME_BITS + 1);
   localparam logic [CW-1:0] LP_FULL = CW'(FRAME_BITS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic                   r_sclk_d;
   logic                   r_cs_d;

   logic w_s_sclk;
   logic w_s_mosi;
   logic w_s_cs_n;
   logic w_sclk_rise;
   logic w_sclk_fall;
   logic w_cs_rise;
   logic w_start;
   logic w_shift_en;

   logic [FRAME_BITS-1:0] r_shift;
   logic [CW-1:0]         r_bit_cnt;
   logic [FRAME_BITS-1:0] r_frame_data;
   logic                  r_frame_valid;
   logic                  r_frame_err;
   logic [7:0]            r_frame_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sclk_sync <= '0;
         r_mosi_sync <= '0;
         r_cs_sync   <= '1;
         r_sclk_d    <= 1'b0;
         r_cs_d      <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
         r_sclk_d    <= w_s_sclk;
         r_cs_d      <= w_s_cs_n;
      end
   end

   assign w_s_sclk    = r_sclk_sync[SYNC_STAGES-1];
   assign w_s_mosi    = r_mosi_sync[SYNC_STAGES-1];
   assign w_s_cs_n    = r_cs_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_s_sclk & ~r_sclk_d;
   assign w_sclk_fall = ~w_s_sclk & r_sclk_d;
   assign w_cs_rise   = w_s_cs_n & ~r_cs_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // IDLE leaves on the cs_n level, so a select that arrives during DONE is not lost
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (!w_s_cs_n) w_state_nxt = ARM;
         ARM:     if (w_sclk_rise) w_state_nxt = SHIFT;
         SHIFT:   w_state_nxt = SHIFT;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (w_cs_rise) w_state_nxt = DONE;
   end

   assign w_start    = (r_state == IDLE) && (w_state_nxt == ARM);
   assign w_shift_en = (r_state == SHIFT) && w_sclk_fall && (r_bit_cnt != LP_FULL);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
      end else if (w_start) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
      end else if (w_shift_en) begin
         r_shift   <= {r_shift[FRAME_BITS-2:0], w_s_mosi};
         r_bit_cnt <= r_bit_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_frame_data  <= '0;
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
         if (r_state == DONE) begin
            if (r_bit_cnt == LP_FULL) begin
               r_frame_data  <= r_shift;
               r_frame_valid <= 1'b1;
               r_frame_count <= r_frame_count + 8'd1;
            end else begin
               r_frame_err <= 1'b1;
            end
         end
      end
   end

   assign frame_data  = r_frame_data;
   assign frame_valid = r_frame_valid;
   assign frame_err   = r_frame_err;
   assign frame_count = r_frame_count;
   assign busy        = ~w_s_cs_n;
   assign a_val       = r_frame_data[FRAME_BITS-1 -: 8];
   assign b_val       = r_frame_data[FRAME_BITS-9 -: 8];
   assign acc_val     = r_frame_data[FRAME_BITS-17 -: 8];
   assign pc_val      = r_frame_data[11:8];
   assign state_val   = r_frame_data[2:0];

endmodule
